mittelwert_seq: RTL and testbench

- Sequential, stream-fed averaging unit for signed 16-bit samples, built around the 4-sample mean (sum, then arithmetic shift).
- Accepts samples one per cycle over a valid/ready handshake and accumulates them with a single adder/subtractor.
- Emits the mean over N = 2^LOG2_N samples, either in block mode (one result per N inputs) or sliding-window mode (one result per input once the window is full).
- Sits between a sample source and a consumer that may apply backpressure.

---
 rtl/mittelwert_seq_if.sv | 22 ++
 rtl/mittelwert_seq.sv | 99 +++++++++
 tb/tb_mittelwert_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mittelwert_seq_if.sv
// Sample-in / mean-out handshake bundle for mittelwert_seq.
// slave is the averaging unit; master is the source+consumer side.
interface mittelwert_seq_if #(
  parameter int DATA_W = 16
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mittelwert_seq.sv
// Streaming mean of 2^LOG2_N signed samples, block or sliding window,
// with one shared add/subtract path and a registered, backpressured result.
module mittelwert_seq #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              mode,
  mittelwert_seq_if.slave   bus,
  output logic [LOG2_N:0]   fill_cnt
);
  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int FW    = LOG2_N + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  acc_t                     acc_q, acc_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [LOG2_N-1:0]        wr_ptr_q, wr_ptr_d;
  logic                     mode_q, mode_d;
  logic                     ov_q, ov_d;
  logic signed [DATA_W-1:0] od_q, od_d;
  logic signed [DATA_W-1:0] buf_q [N];

  logic accept, mode_cond, mode_eff, full, done;
  acc_t sub, sum;

  assign bus.in_ready  = rst_n & ~clear & (~ov_q | bus.out_ready);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign fill_cnt      = fill_q;

  assign accept    = bus.in_valid & bus.in_ready;
  // Mode only changes while the unit is idle; using the live value in that
  // cycle lets the very first sample already follow the new mode.
  assign mode_cond = (fill_q == '0) && !ov_q;
  assign mode_eff  = mode_cond ? mode : mode_q;
  assign full      = (fill_q == FW'(N));
  assign sub       = (mode_eff && full) ? acc_t'(buf_q[wr_ptr_q]) : '0;
  assign sum       = acc_q + acc_t'(bus.in_data) - sub;
  assign done      = accept && (mode_eff ? (fill_q >= FW'(N-1))
                                         : (fill_q == FW'(N-1)));

  always_comb begin
    acc_d    = acc_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    mode_d   = mode_eff;
    ov_d     = ov_q;
    od_d     = od_q;
    if (clear) begin
      acc_d    = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
      ov_d     = 1'b0;
    end else begin
      if (ov_q && bus.out_ready) ov_d = 1'b0;
      if (accept) begin
        wr_ptr_d = wr_ptr_q + LOG2_N'(1);
        acc_d    = sum;
        fill_d   = full ? fill_q : fill_q + FW'(1);
        if (done) begin
          ov_d = 1'b1;
          od_d = sum[ACC_W-1:LOG2_N];
          if (!mode_eff) begin
            acc_d  = '0;
            fill_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      mode_q   <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      mode_q   <= mode_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
    end
  end

  // Window storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (accept) buf_q[wr_ptr_q] <= bus.in_data;
  end
endmodule

// File: tb/tb_mittelwert_seq.sv
// Directed bench for mittelwert_seq: block, sliding, backpressure, clear, reset.
module tb_mittelwert_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] fill_cnt;
  int         checks = 0;
  int         errors = 0;

  mittelwert_seq_if #(.DATA_W(16)) bus ();

  mittelwert_seq #(.DATA_W(16), .LOG2_N(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mode     (mode),
    .bus      (bus),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(d);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_fill", {29'b0, fill_cnt}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", {31'b0, bus.in_ready}, 1);

    // block mode, plain average
    put(100); put(200); put(300);
    chk("t1_fill3", {29'b0, fill_cnt}, 3);
    chk("t1_no_out", {31'b0, bus.out_valid}, 0);
    put(400);
    chk("t1_valid", {31'b0, bus.out_valid}, 1);
    chk("t1_data", 32'(bus.out_data), 250);
    chk("t1_fill0", {29'b0, fill_cnt}, 0);
    step();
    chk("t1_drop", {31'b0, bus.out_valid}, 0);

    // floor rounding and extremes
    put(-1); put(-1); put(-1); put(-2);
    chk("t2_floor", 32'(bus.out_data), -2);
    put(-32768); put(-32768); put(-32768); put(-32768);
    chk("t2_min_v", {31'b0, bus.out_valid}, 1);
    chk("t2_min", 32'(bus.out_data), -32768);
    put(32767); put(32767); put(32767); put(32767);
    chk("t2_max", 32'(bus.out_data), 32767);
    step();

    // sliding window
    mode = 1'b1;
    step();
    put(4); put(8); put(12);
    chk("t3_no_out", {31'b0, bus.out_valid}, 0);
    chk("t3_fill3", {29'b0, fill_cnt}, 3);
    put(16);
    chk("t3_v1", {31'b0, bus.out_valid}, 1);
    chk("t3_d1", 32'(bus.out_data), 10);
    put(20);
    chk("t3_d2", 32'(bus.out_data), 14);
    put(24);
    chk("t3_d3", 32'(bus.out_data), 18);
    chk("t3_fill_sat", {29'b0, fill_cnt}, 4);

    // backpressure with window full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'sd28;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready", {31'b0, bus.in_ready}, 0);
      step();
      chk("t4_hold_v", {31'b0, bus.out_valid}, 1);
      chk("t4_hold_d", 32'(bus.out_data), 18);
    end
    chk("t4_fill", {29'b0, fill_cnt}, 4);
    bus.out_ready = 1'b1;
    #1;
    chk("t4_release_rdy", {31'b0, bus.in_ready}, 1);
    step();
    bus.in_valid = 1'b0;
    chk("t4_new_v", {31'b0, bus.out_valid}, 1);
    chk("t4_new_d", 32'(bus.out_data), 22);
    step();
    chk("t4_drop", {31'b0, bus.out_valid}, 0);

    // clear flushes partial block; mid-fill mode toggle ignored
    mode  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    put(7); put(9);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd1000;
    clear = 1'b1;
    #1;
    chk("t5_clr_rdy", {31'b0, bus.in_ready}, 0);
    step();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_clr_fill", {29'b0, fill_cnt}, 0);
    chk("t5_clr_v", {31'b0, bus.out_valid}, 0);
    put(40);
    mode = 1'b1;
    put(40); put(40); put(40);
    chk("t5_v", {31'b0, bus.out_valid}, 1);
    chk("t5_d", 32'(bus.out_data), 40);
    chk("t5_block_fill", {29'b0, fill_cnt}, 0);
    mode = 1'b0;
    step();
    chk("t5_drop", {31'b0, bus.out_valid}, 0);

    // async reset while a result is pending
    bus.out_ready = 1'b0;
    put(1); put(2); put(3); put(4);
    chk("t6_pre_v", {31'b0, bus.out_valid}, 1);
    chk("t6_pre_d", 32'(bus.out_data), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", {31'b0, bus.out_valid}, 0);
    chk("t6_rst_d", 32'(bus.out_data), 0);
    chk("t6_rst_fill", {29'b0, fill_cnt}, 0);
    chk("t6_rst_rdy", {31'b0, bus.in_ready}, 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    put(4); put(4); put(4); put(4);
    chk("t6_v", {31'b0, bus.out_valid}, 1);
    chk("t6_d", 32'(bus.out_data), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
